// File: rtl/bitwise_result_sequencer.sv
// Captures a 7-result bitwise set per handshake and replays it one beat
// at a time with index/last tags, a frame counter and a sticky check flag.
module bitwise_result_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] and_in,
  input  logic [WIDTH-1:0] or_in,
  input  logic [WIDTH-1:0] xor_in,
  input  logic [WIDTH-1:0] not_in,
  input  logic [WIDTH-1:0] nand_in,
  input  logic [WIDTH-1:0] nor_in,
  input  logic [WIDTH-1:0] xnor_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_idx,
  output logic             out_last,
  output logic [7:0]       frame_cnt,
  output logic             err
);

  localparam logic       IDLE = 1'b0;
  localparam logic       SEND = 1'b1;
  localparam logic [2:0] LAST = 3'd6;

  logic             state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       frame_q, frame_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] arr_q [7];

  logic in_xfer;
  logic out_xfer;
  logic mismatch;

  // Ready early on the last beat so the next frame follows with no bubble.
  assign in_ready  = (state_q == IDLE) ||
                     (idx_q == LAST && out_ready);
  assign out_valid = (state_q == SEND);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  assign mismatch = (nand_in != ~and_in) ||
                    (nor_in  != ~or_in)  ||
                    (xnor_in != ~xor_in);

  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == LAST);
  assign frame_cnt = frame_q;
  assign err       = err_q;

  always_comb begin
    out_data = '0;
    case (idx_q)
      3'd0:    out_data = arr_q[0];
      3'd1:    out_data = arr_q[1];
      3'd2:    out_data = arr_q[2];
      3'd3:    out_data = arr_q[3];
      3'd4:    out_data = arr_q[4];
      3'd5:    out_data = arr_q[5];
      3'd6:    out_data = arr_q[6];
      default: out_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    err_d   = err_q;
    if (out_xfer) begin
      if (idx_q == LAST) begin
        frame_d = frame_q + 8'd1;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
    if (in_xfer) begin
      state_d = SEND;
      idx_d   = '0;
      if (mismatch) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) arr_q[i] <= '0;
    end else if (in_xfer) begin
      arr_q[0] <= and_in;
      arr_q[1] <= or_in;
      arr_q[2] <= xor_in;
      arr_q[3] <= not_in;
      arr_q[4] <= nand_in;
      arr_q[5] <= nor_in;
      arr_q[6] <= xnor_in;
    end
  end

endmodule

// File: doc/bitwise_result_sequencer.md
# bitwise_result_sequencer

Downstream stage of the 4-bit bitwise operator unit. It captures one complete result set (AND, OR, XOR, NOT-A, NAND, NOR, XNOR) per valid/ready handshake. It then emits the seven results one per beat on a narrow valid/ready stream tagged with an index and last flag. It also keeps a frame counter and a sticky consistency-error flag that checks the complemented results against their base results.

## Interface
- WIDTH, default 4, width of every result bus and of out_data.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  result set on the *_in buses is valid.
- in_ready  output  1  block can accept a result set this cycle.
- and_in, or_in, xor_in, not_in, nand_in, nor_in, xnor_in  input  WIDTH each  results from the operator unit.
- out_valid  output  1  out_data/out_idx/out_last are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_data  output  WIDTH  current result.
- out_idx  output  3  beat index, 0..6.
- out_last  output  1  high on beat 6.
- frame_cnt  output  8  count of completed frames; wraps from 255 to 0.
- err  output  1  sticky consistency error.

## Operation
- FSM states are IDLE and SEND. Reset state is IDLE.
- Input transfer occurs when in_valid && in_ready. On a transfer, all seven inputs are registered into a 7-entry result array, idx is set to 0, and the state becomes SEND.
- Emission order by idx: 0 AND, 1 OR, 2 XOR, 3 NOT, 4 NAND, 5 NOR, 6 XNOR.
- In SEND:
  - out_valid = 1.
  - out_data = array[idx].
  - out_idx = idx.
  - out_last = (idx == 6).
- Output transfer occurs when out_valid && out_ready.
  - If idx < 6, idx increments.
  - If idx == 6, frame_cnt increments (mod 256). The state then returns to IDLE, unless a new input transfer happens in the same cycle.
- in_ready = (state == IDLE) || (state == SEND && idx == 6 && out_ready). This gives back-to-back frames with no bubble.
  - in_ready has a combinational path from out_ready. This is intentional.
- If the last-beat transfer and an input transfer occur in the same cycle: the array is reloaded, idx = 0, the state stays SEND, and frame_cnt still increments.
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_last hold stable. The array is not modified.
- Consistency check on every input transfer:
  - err is set if nand_in != ~and_in, nor_in != ~or_in, or xnor_in != ~xor_in.
  - err stays set until reset. The frame is still captured and emitted normally.
  - not_in is not checked, because the block does not see operand a.
- in_valid while in_ready = 0 is ignored. The upstream holds its data.

## Timing
- All outputs are registered except in_ready (state plus out_ready) and out_last (decoded from registered idx).
- Reset values: out_valid 0, out_idx 0, out_data 0 (array cleared), out_last 0, frame_cnt 0, err 0, in_ready 1.
- Latency: an input accepted at edge N gives out_valid = 1 and beat 0 in the cycle after edge N.
- Throughput with out_ready held high: 7 beats per 7 cycles, back-to-back, with continuous out_valid across frames.
- Isolated frame: 7 output cycles, then in_ready = 1 in IDLE.
- Reset asserted mid-frame discards the partial frame. frame_cnt is not incremented, and out_valid drops to 0 immediately (asynchronously).
- frame_cnt wraps 255 -> 0 without any flag.

## Test plan
- Reset, then in_valid with results of a=4'b1100, b=4'b1010 (AND 8, OR E, XOR 6, NOT 3, NAND 7, NOR 1, XNOR 9), out_ready = 1 -> beats 8,E,6,3,7,1,9 on 7 consecutive cycles with idx 0..6, out_last only on idx 6, frame_cnt = 1, err = 0.
- Same frame with out_ready toggling 1/0 every cycle -> identical data/idx sequence, outputs stable during stalls, 13 cycles from the first beat to the last-beat transfer.
- Two frames presented back-to-back (second in_valid held high), out_ready = 1 -> second frame accepted in the last-beat cycle of the first, 14 continuous valid beats, frame_cnt = 2.
- Frame with nand_in = 4'h6 and and_in = 4'h8 -> err = 1 after the capture edge, frame still emitted, err remains 1 through later clean frames until rst_n low.
- Assert rst_n low during beat 3 of a frame -> out_valid, out_idx and frame_cnt return to 0 immediately, in_ready = 1 after release, next frame emits from idx 0.
- 256 complete frames -> frame_cnt reads 0 after the 256th last beat, err = 0.
